key_input_conditioner: RTL and testbench

// Front-end for the pong top level: turns the four raw active-low KEY buttons into clean

---
 rtl/key_input_conditioner_pkg.sv | 31 +++
 rtl/key_input_conditioner_if.sv | 34 +++
 rtl/key_input_conditioner_debouncer.sv | 69 ++++++
 rtl/key_input_conditioner.sv | 161 ++++++++++++++++
 tb/tb_key_input_conditioner.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_input_conditioner_pkg.sv
// Shared constants, types and helpers for the pong key front-end.
// Key index constants name the role of each KEY button; BOOST_W is the
// paddle boost width; boost_state_t encodes the hold-to-accelerate FSM.
package key_input_conditioner_pkg;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_START = 3;
  localparam int BOOST_W   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } boost_state_t;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [BOOST_W-1:0] boost_sat_inc(
    input logic [BOOST_W-1:0] value,
    input logic [BOOST_W-1:0] max_value
  );
    logic [BOOST_W-1:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + {{(BOOST_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/key_input_conditioner_if.sv
// Game-control bundle between the raw board buttons and the pong update logic.
//   KEY        raw active-low buttons (async to the clock)
//   game_over  level from ball logic, forces start low
//   key_level  debounced key state, 1 = pressed
//   key_press  one-cycle pulse on debounced press
//   start      game running flag
//   tick       one-cycle move strobe
//   move_right / move_left  single-direction paddle move, gated by start
//   boost      paddle step size
// slave: the conditioner; master: whatever drives the buttons and consumes controls.
interface key_input_conditioner_if;
  import key_input_conditioner_pkg::*;

  logic [NUM_KEYS-1:0] KEY;
  logic                game_over;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic                start;
  logic                tick;
  logic                move_right;
  logic                move_left;
  logic [BOOST_W-1:0]  boost;

  modport slave (
    input  KEY, game_over,
    output key_level, key_press, start, tick, move_right, move_left, boost
  );

  modport master (
    output KEY, game_over,
    input  key_level, key_press, start, tick, move_right, move_left, boost
  );

endinterface

// File: rtl/key_input_conditioner_debouncer.sv
// One-key conditioner: 2-FF synchroniser, stability counter, debounced level
// and press pulse.
//   CLOCK_50   system clock
//   reset      synchronous, active-high
//   key_n      raw button, active-low, asynchronous
//   key_level  debounced state, 1 = pressed
//   key_press  one-cycle pulse in the cycle key_level rises
// The level follows the synchronised sample only after DEB_CYCLES consecutive
// cycles of disagreement; any agreeing cycle throws the progress away.
module key_input_conditioner_debouncer #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press
);

  localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_r;
  logic             sync2_r;
  logic             sample_s;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             press_r;

  // Both stages hold raw polarity so reset (1) reads as released; the
  // inversion to active-high happens on the second stage's output.
  assign sample_s = ~sync2_r;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter, accepted level and press pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else if (sample_s == level_r) begin
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= CNT_ZERO;
      level_r <= sample_s;
      press_r <= sample_s;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
      press_r <= 1'b0;
    end
  end

  assign key_level = level_r;
  assign key_press = press_r;

endmodule

// File: rtl/key_input_conditioner.sv
// Pong front-end: turns the four raw KEY buttons into game controls.
//   CLOCK_50  system clock
//   reset     synchronous, active-high
//   bus       key_input_conditioner_if.slave (KEY, game_over in; key_level,
//             key_press, start, tick, move_right, move_left, boost out)
// Four debouncers feed a start/pause flag (KEY[3]), a free-running move
// strobe and a hold-to-accelerate boost ramp on the direction keys.
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int TICK_DIV   = 262_144,
  parameter int BOOST_DIV  = 8_388_608,
  parameter int BOOST_MAX  = 31
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  key_input_conditioner_if.slave  bus
);

  localparam int                 TICK_W      = $clog2(TICK_DIV);
  localparam int                 BDIV_W      = $clog2(BOOST_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE    = TICK_W'(1);
  localparam logic [TICK_W-1:0]  TICK_ZERO   = TICK_W'(0);
  localparam logic [BDIV_W-1:0]  BDIV_LAST   = BDIV_W'(BOOST_DIV - 1);
  localparam logic [BDIV_W-1:0]  BDIV_ONE    = BDIV_W'(1);
  localparam logic [BDIV_W-1:0]  BDIV_ZERO   = BDIV_W'(0);
  localparam logic [BOOST_W-1:0] BOOST_ONE   = BOOST_W'(1);
  localparam logic [BOOST_W-1:0] BOOST_MAX_V = BOOST_W'(BOOST_MAX);

  if ((BOOST_MAX < 1) || (BOOST_MAX > (2 ** BOOST_W) - 1)) begin : g_boost_max_err
    $error("BOOST_MAX must lie in 1..%0d", (2 ** BOOST_W) - 1);
  end

  logic [NUM_KEYS-1:0] key_level_s;
  logic [NUM_KEYS-1:0] key_press_s;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic                tick_r;
  logic                start_r;
  logic [1:0]          dir_now_s;
  logic [1:0]          dir_r;
  logic                held_one_s;
  logic                dir_same_s;
  boost_state_t        state_r;
  boost_state_t        state_nx_s;
  logic [BDIV_W-1:0]   bdiv_r;
  logic [BDIV_W-1:0]   bdiv_nx_s;
  logic [BOOST_W-1:0]  boost_r;
  logic [BOOST_W-1:0]  boost_nx_s;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_input_conditioner_debouncer #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .key_n     (bus.KEY[i]),
      .key_level (key_level_s[i]),
      .key_press (key_press_s[i])
    );
  end

  // Free-running move strobe, high for the cycle after the counter's last value.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_cnt_r <= TICK_ZERO;
      tick_r     <= 1'b0;
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= TICK_ZERO;
      tick_r     <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
      tick_r     <= 1'b0;
    end
  end

  // Start/pause flag; game_over takes priority over a simultaneous press.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      start_r <= 1'b0;
    end else if (bus.game_over) begin
      start_r <= 1'b0;
    end else if (key_press_s[KEY_START]) begin
      start_r <= 1'b1;
    end else begin
      start_r <= start_r;
    end
  end

  assign dir_now_s  = {key_level_s[KEY_LEFT], key_level_s[KEY_RIGHT]};
  assign held_one_s = key_level_s[KEY_RIGHT] ^ key_level_s[KEY_LEFT];
  // A jump from one single key to the other counts as a release.
  assign dir_same_s = (dir_now_s == dir_r);

  // Previous direction pair, used to spot a direct left/right swap.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dir_r <= 2'b00;
    end else begin
      dir_r <= dir_now_s;
    end
  end

  // Boost FSM state, divider and boost value registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= IDLE;
      bdiv_r  <= BDIV_ZERO;
      boost_r <= BOOST_ONE;
    end else begin
      state_r <= state_nx_s;
      bdiv_r  <= bdiv_nx_s;
      boost_r <= boost_nx_s;
    end
  end

  // Boost FSM next state: ramp while exactly one direction key stays held.
  always_comb begin
    state_nx_s = state_r;
    bdiv_nx_s  = bdiv_r;
    boost_nx_s = boost_r;
    case (state_r)
      IDLE: begin
        bdiv_nx_s  = BDIV_ZERO;
        boost_nx_s = BOOST_ONE;
        if (held_one_s) begin
          state_nx_s = HOLD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      HOLD: begin
        if (!held_one_s || !dir_same_s) begin
          state_nx_s = IDLE;
          bdiv_nx_s  = BDIV_ZERO;
          boost_nx_s = BOOST_ONE;
        end else if (bdiv_r == BDIV_LAST) begin
          bdiv_nx_s  = BDIV_ZERO;
          boost_nx_s = boost_sat_inc(boost_r, BOOST_MAX_V);
        end else begin
          bdiv_nx_s  = bdiv_r + BDIV_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        bdiv_nx_s  = BDIV_ZERO;
        boost_nx_s = BOOST_ONE;
      end
    endcase
  end

  assign bus.key_level  = key_level_s;
  assign bus.key_press  = key_press_s;
  assign bus.start      = start_r;
  assign bus.tick       = tick_r;
  assign bus.move_right = key_level_s[KEY_RIGHT] & ~key_level_s[KEY_LEFT] & start_r;
  assign bus.move_left  = key_level_s[KEY_LEFT] & ~key_level_s[KEY_RIGHT] & start_r;
  assign bus.boost      = boost_r;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner with small parameters. A cycle model built
// from the behavioural rules (sample delay, run-of-equal-samples acceptance,
// run-length boost ramp, edge-count tick) is compared against the DUT on every
// falling edge; directed scenarios add hand-computed literal expectations.
module tb_key_input_conditioner;
  import key_input_conditioner_pkg::*;

  localparam int DEB  = 4;
  localparam int TDIV = 8;
  localparam int BDIV = 16;
  localparam int BMAX = 5;

  logic CLOCK_50 = 1'b0;
  logic reset;

  key_input_conditioner_if bus ();

  key_input_conditioner #(
    .DEB_CYCLES (DEB),
    .TICK_DIV   (TDIV),
    .BOOST_DIV  (BDIV),
    .BOOST_MAX  (BMAX)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]     m_level, m_press, m_level_prev, dly1, dly2, sample;
  logic [DEB-1:0] win [4];
  logic           m_start, m_tick;
  logic [1:0]     l1, l2;
  int             m_boost, run, edge_cnt, b;
  bit             model_ok = 1'b0;

  function automatic bit single_dir(input logic [1:0] d);
    return (d == 2'b01) || (d == 2'b10);
  endfunction

  always @(posedge CLOCK_50) begin
    if (reset) begin
      m_level = 4'h0; m_press = 4'h0; m_level_prev = 4'h0;
      dly1 = 4'h0; dly2 = 4'h0;
      for (int k = 0; k < 4; k++) win[k] = '0;
      m_start = 1'b0; m_tick = 1'b0;
      run = 0; m_boost = 1; edge_cnt = 0;
    end else begin
      if (bus.game_over) m_start = 1'b0;
      else if (m_press[3]) m_start = 1'b1;
      // boost: length of the current uninterrupted single-direction hold
      l1 = m_level[1:0];
      l2 = m_level_prev[1:0];
      if (single_dir(l1) && l1 == l2) run = run + 1;
      else if (single_dir(l1) && !single_dir(l2)) run = 1;
      else run = 0;
      b = 1 + (run - 1) / BDIV;
      if (b > BMAX) b = BMAX;
      m_boost = (run == 0) ? 1 : b;
      m_level_prev = m_level;
      // debounce: sample is the pressed state from two cycles back
      sample = dly2;
      dly2 = dly1;
      dly1 = ~bus.KEY;
      m_press = 4'h0;
      for (int k = 0; k < 4; k++) begin
        win[k] = {win[k][DEB-2:0], sample[k]};
        if (win[k] == {DEB{~m_level[k]}}) begin
          m_level[k] = ~m_level[k];
          m_press[k] = m_level[k];
        end
      end
      edge_cnt++;
      m_tick = ((edge_cnt % TDIV) == 0);
    end
    model_ok = 1'b1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (model_ok) begin
      check("key_level",  int'(bus.key_level),  int'(m_level));
      check("key_press",  int'(bus.key_press),  int'(m_press));
      check("start",      int'(bus.start),      int'(m_start));
      check("tick",       int'(bus.tick),       int'(m_tick));
      check("move_right", int'(bus.move_right), int'(m_level[0] & ~m_level[1] & m_start));
      check("move_left",  int'(bus.move_left),  int'(m_level[1] & ~m_level[0] & m_start));
      check("boost",      int'(bus.boost),      m_boost);
    end
  end

  // Press KEY[3] for 10 cycles; optionally raise game_over to coincide with the press pulse.
  task automatic press_start(input bit with_go, input int exp_start, input string tag);
    int rise_at = 0;
    int np = 0;
    bus.KEY[3] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLOCK_50);
      if (bus.key_level[3] && rise_at == 0) rise_at = i;
      if (bus.key_press[3]) np++;
      if (i == 6 && with_go) bus.game_over = 1'b1;
      if (i == 7) begin
        check({tag, "_start"}, int'(bus.start), exp_start);
        bus.game_over = 1'b0;
      end
    end
    check({tag, "_rise_cycle"}, rise_at, 6);
    check({tag, "_press_count"}, np, 1);
    bus.KEY[3] = 1'b1;
    repeat (12) @(negedge CLOCK_50);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int nt, first, np, r0, r3;
    bus.KEY = 4'hF;
    bus.game_over = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("reset_boost", int'(bus.boost), 1);
    check("reset_level", int'(bus.key_level), 0);
    reset = 1'b0;

    // idle: ticks at 8,16,24,32,40
    nt = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLOCK_50);
      if (bus.tick) begin
        nt++;
        if (first == 0) first = i;
      end
    end
    check("idle_tick_count", nt, 5);
    check("idle_first_tick", first, 8);
    check("idle_boost", int'(bus.boost), 1);
    check("idle_start", int'(bus.start), 0);

    // 3-cycle glitch on KEY[3] is rejected
    bus.KEY[3] = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    bus.KEY[3] = 1'b1;
    np = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLOCK_50);
      if (bus.key_press[3]) np++;
    end
    check("glitch_press_count", np, 0);
    check("glitch_start", int'(bus.start), 0);

    // start, then game_over against a fresh press, then start again
    press_start(1'b0, 1, "start1");
    press_start(1'b1, 0, "gameover");
    press_start(1'b0, 1, "start2");

    // hold KEY[0]: level at 6, boost steps at 23,39,55,71
    bus.KEY[0] = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge CLOCK_50);
      case (i)
        10: begin
          check("hold_move_right", int'(bus.move_right), 1);
          check("hold_move_left", int'(bus.move_left), 0);
        end
        22:  check("hold_boost_22", int'(bus.boost), 1);
        23:  check("hold_boost_23", int'(bus.boost), 2);
        39:  check("hold_boost_39", int'(bus.boost), 3);
        55:  check("hold_boost_55", int'(bus.boost), 4);
        71:  check("hold_boost_71", int'(bus.boost), 5);
        120: check("hold_boost_sat", int'(bus.boost), 5);
        default: ;
      endcase
    end
    bus.KEY[0] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge CLOCK_50);
      if (j == 6) begin
        check("release_level0", int'(bus.key_level[0]), 0);
        check("release_boost_6", int'(bus.boost), 5);
      end
      if (j == 7) check("release_boost_7", int'(bus.boost), 1);
    end
    repeat (4) @(negedge CLOCK_50);

    // both direction keys: no movement, no boost
    bus.KEY[1:0] = 2'b00;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLOCK_50);
      if (i == 20) begin
        check("both_level", int'(bus.key_level[1:0]), 3);
        check("both_move_right", int'(bus.move_right), 0);
        check("both_move_left", int'(bus.move_left), 0);
      end
      if (i == 40) check("both_boost", int'(bus.boost), 1);
    end
    bus.KEY[1:0] = 2'b11;
    repeat (12) @(negedge CLOCK_50);

    // direct right->left swap restarts the ramp
    bus.KEY[0] = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge CLOCK_50);
      if (i == 30) begin
        check("swap_boost_before", int'(bus.boost), 2);
        bus.KEY[0] = 1'b1;
        bus.KEY[1] = 1'b0;
      end
      if (i == 36) check("swap_level", int'(bus.key_level[1:0]), 2);
      if (i == 37) begin
        check("swap_boost_after", int'(bus.boost), 1);
        check("swap_move_left", int'(bus.move_left), 1);
      end
      if (i == 45) check("swap_boost_later", int'(bus.boost), 1);
    end
    bus.KEY[1] = 1'b1;
    repeat (12) @(negedge CLOCK_50);

    // reset mid-hold (boost=4) and mid-debounce on KEY[3]
    bus.KEY[0] = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge CLOCK_50);
      if (i == 55) bus.KEY[3] = 1'b0;
    end
    check("prereset_boost", int'(bus.boost), 4);
    check("prereset_level3", int'(bus.key_level[3]), 0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("midreset_boost", int'(bus.boost), 1);
    check("midreset_level", int'(bus.key_level), 0);
    check("midreset_start", int'(bus.start), 0);
    reset = 1'b0;
    r0 = 0; r3 = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge CLOCK_50);
      if (bus.key_level[0] && r0 == 0) r0 = j;
      if (bus.key_level[3] && r3 == 0) r3 = j;
    end
    check("postreset_rise0", r0, 6);
    check("postreset_rise3", r3, 6);
    bus.KEY = 4'hF;
    repeat (12) @(negedge CLOCK_50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
